gray_to_rgb565: RTL and testbench
=================================

# gray_to_rgb565

Streaming expander that converts 8-bit grayscale pixels back into RGB565 words, with optional 2x2 ordered dithering and a full ready/valid handshake on both sides. It sits between the grayscale processing path and any RGB565 consumer (frame buffer writer, display/output formatter), reversing the packing used on the RGB-to-gray side. The block provides registered backpressure through a one-entry skid buffer and passes start-of-frame/end-of-line markers through alongside the pixels.

## Interface
- DITHER, 1: 1 = 2x2 ordered dither before truncation; 0 = plain truncation.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- pixel_in  in  8  gray value.
- pixel_in_valid  in  1  input word present.
- pixel_in_sof  in  1  first pixel of frame (qualified by valid).
- pixel_in_eol  in  1  last pixel of line (qualified by valid).
- pixel_in_ready  out  1  registered; block can accept this cycle.
- pixel_out  out  16  RGB565 {r5, g6, b5}.
- pixel_out_valid  out  1  output word present.
- pixel_out_sof  out  1  sof travelling with pixel_out.
- pixel_out_eol  out  1  eol travelling with pixel_out.
- pixel_out_ready  in  1  downstream accepts.

## Operation
- Transfer occurs on an edge where valid & ready are both high, on either side.
- Position tracking uses col_par and row_par (1 bit each). Both reset to 0.
  - An accepted pixel with sof uses position (0,0), regardless of the counters.
  - After each accepted pixel, col_par toggles, or clears to 0 if eol is set.
  - row_par toggles on an accepted eol. On an accepted sof pixel, row_par is forced to 0 (and to 1 if that pixel also has eol).
- Dither index m from {row_par, col_par}: (0,0)=0, (0,1)=2, (1,0)=3, (1,1)=1.
  - off5 = 2*m, off6 = m.
  - With DITHER=0, both offsets are 0.
- Arithmetic uses a 9-bit sum, saturated after the shift:
  - r5 = b5 = min(31, (gray+off5)>>3).
  - g6 = min(63, (gray+off6)>>2).
  - pixel_out = {r5, g6, b5}.
- Buffering uses output register O and skid register S:
  - Accepted pixel goes to O if O is empty or O drains this edge and S is empty. Otherwise it goes to S.
  - When O drains and S is full, S moves to O.
  - pixel_in_ready is registered: it equals !S_full as computed for the next cycle.
- Ordering is strictly preserved: no drops, no duplicates, and sof/eol stay attached to their pixel.

## Timing
- Reset values:
  - pixel_out = 0, pixel_out_valid = 0, pixel_out_sof = 0, pixel_out_eol = 0.
  - pixel_in_ready = 0.
  - O and S are empty, col_par = row_par = 0.
- pixel_in_ready rises on the first edge with reset low.
- Latency: a pixel accepted at edge N is presented on pixel_out in the cycle after edge N, when O is empty or draining.
- Throughput: 1 pixel/clk while pixel_out_ready is held high.
- Stall behaviour:
  - When pixel_out_ready drops, at most one additional pixel is accepted (into S).
  - pixel_in_ready is low from the next cycle.
  - pixel_out and the sideband outputs hold stable while valid & !ready.
- Recovery: after pixel_out_ready returns high, pixel_in_ready rises one edge after S empties.
- Simultaneous O-drain and input accept with S empty: the new pixel loads O on the same edge, with no bubble.
- Reset mid-stream:
  - Everything returns to its reset values on that edge and any in-flight pixels are discarded.
  - Parity restarts at (0,0).
- sof arriving mid-line: position restarts at (0,0) for that pixel, and no error is flagged.

## Test plan
- DITHER=0, streaming 0xFF, 0x80, 0x00 with out_ready=1: the outputs are 0xFFFF, 0x8410, 0x0000, each one cycle after acceptance.
- DITHER=1, gray 0x84, 2x2 frame (sof on first pixel, eol on pixels 2 and 4): the outputs are 0x8430, 0x8C31, 0x8C31, 0x8430.
- DITHER=1, gray 0xFE at position (1,0): r and b saturate to 31 and g saturates to 63, giving 0xFFFF.
- Continuous valid input with out_ready low for 5 cycles:
  - Exactly one extra accept occurs.
  - pixel_in_ready is low for the stall.
  - pixel_out stays stable.
  - After release, the full sequence arrives in order with sof/eol intact and no gaps.
- Reset asserted mid-line with O and S full:
  - The next cycle shows all outputs at 0 and pixel_in_ready=0.
  - The first pixel after reset uses position (0,0).
- sof on the 3rd pixel of a line (DITHER=1, gray 0x84): that pixel outputs 0x8430 and the following pixel outputs 0x8C31.

Source files
------------

// File: rtl/gray_to_rgb565.sv
// gray_to_rgb565: streaming expander from 8-bit grayscale to RGB565.
// Each gray value is replicated onto R/G/B, optionally offset by a 2x2
// ordered-dither threshold selected by frame position, then truncated with
// saturation. A one-entry skid buffer behind the output register gives a
// fully registered pixel_in_ready.
//
// Parameters:
//   DITHER          1 = 2x2 ordered dither before truncation, 0 = truncate only
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-high
//   pixel_in        gray value
//   pixel_in_valid  input word present
//   pixel_in_sof    first pixel of frame (qualified by valid)
//   pixel_in_eol    last pixel of line (qualified by valid)
//   pixel_in_ready  registered; block accepts this cycle
//   pixel_out       RGB565 {r5, g6, b5}
//   pixel_out_valid output word present
//   pixel_out_sof   sof travelling with pixel_out
//   pixel_out_eol   eol travelling with pixel_out
//   pixel_out_ready downstream accepts
module gray_to_rgb565 #(
   parameter int unsigned DITHER = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  pixel_in,
   input  logic        pixel_in_valid,
   input  logic        pixel_in_sof,
   input  logic        pixel_in_eol,
   output logic        pixel_in_ready,
   output logic [15:0] pixel_out,
   output logic        pixel_out_valid,
   output logic        pixel_out_sof,
   output logic        pixel_out_eol,
   input  logic        pixel_out_ready
);

   localparam int unsigned GW = 8;   // gray width
   localparam int unsigned PW = 16;  // RGB565 width
   localparam int unsigned SW = 9;   // dither sum width

   // output register O
   logic          o_valid_q, o_valid_d;
   logic [PW-1:0] o_data_q,  o_data_d;
   logic          o_sof_q,   o_sof_d;
   logic          o_eol_q,   o_eol_d;
   // skid register S
   logic          s_valid_q, s_valid_d;
   logic [PW-1:0] s_data_q,  s_data_d;
   logic          s_sof_q,   s_sof_d;
   logic          s_eol_q,   s_eol_d;
   // position parity and registered ready
   logic          col_par_q, col_par_d;
   logic          row_par_q, row_par_d;
   logic          ready_q,   ready_d;

   logic          row_use, col_use;
   logic [1:0]    m_c;
   logic [SW-1:0] sum5, sum6;
   logic [5:0]    r_sh;
   logic [6:0]    g_sh;
   logic [4:0]    r5;
   logic [5:0]    g6;
   logic [PW-1:0] px_new;
   logic          in_fire, out_fire;

   // Dither index from position; sof forces (0,0) for its own pixel.
   always_comb begin
      row_use = pixel_in_sof ? 1'b0 : row_par_q;
      col_use = pixel_in_sof ? 1'b0 : col_par_q;
      unique case ({row_use, col_use})
         2'b00:   m_c = 2'd0;
         2'b01:   m_c = 2'd2;
         2'b10:   m_c = 2'd3;
         default: m_c = 2'd1;
      endcase
      if (DITHER == 0) m_c = 2'd0;
   end

   // Offset, shift and saturate; the shifted value overflows only when the
   // 9-bit sum reaches 256, i.e. when its top bit is set.
   always_comb begin
      sum5   = SW'(pixel_in) + SW'({m_c, 1'b0});
      sum6   = SW'(pixel_in) + SW'(m_c);
      r_sh   = 6'(sum5 >> 3);
      g_sh   = 7'(sum6 >> 2);
      r5     = r_sh[5] ? 5'd31 : r_sh[4:0];
      g6     = g_sh[6] ? 6'd63 : g_sh[5:0];
      px_new = {r5, g6, r5};
   end

   // Handshake, O/S buffering and position update.
   always_comb begin
      o_valid_d = o_valid_q;
      o_data_d  = o_data_q;
      o_sof_d   = o_sof_q;
      o_eol_d   = o_eol_q;
      s_valid_d = s_valid_q;
      s_data_d  = s_data_q;
      s_sof_d   = s_sof_q;
      s_eol_d   = s_eol_q;
      col_par_d = col_par_q;
      row_par_d = row_par_q;

      in_fire  = pixel_in_valid & ready_q;
      out_fire = o_valid_q & pixel_out_ready;

      if (out_fire) begin
         if (s_valid_q) begin
            o_data_d  = s_data_q;
            o_sof_d   = s_sof_q;
            o_eol_d   = s_eol_q;
            s_valid_d = 1'b0;
         end else begin
            o_valid_d = 1'b0;
         end
      end

      if (in_fire) begin
         // ready_q guarantees S is empty whenever a pixel is accepted
         if (!o_valid_q || (out_fire && !s_valid_q)) begin
            o_valid_d = 1'b1;
            o_data_d  = px_new;
            o_sof_d   = pixel_in_sof;
            o_eol_d   = pixel_in_eol;
         end else begin
            s_valid_d = 1'b1;
            s_data_d  = px_new;
            s_sof_d   = pixel_in_sof;
            s_eol_d   = pixel_in_eol;
         end
         col_par_d = pixel_in_eol ? 1'b0 : ~col_use;
         row_par_d = pixel_in_eol ? ~row_use : row_use;
      end

      ready_d = ~s_valid_d;
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
         o_sof_q   <= 1'b0;
         o_eol_q   <= 1'b0;
         s_valid_q <= 1'b0;
         s_data_q  <= '0;
         s_sof_q   <= 1'b0;
         s_eol_q   <= 1'b0;
         col_par_q <= 1'b0;
         row_par_q <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         o_valid_q <= o_valid_d;
         o_data_q  <= o_data_d;
         o_sof_q   <= o_sof_d;
         o_eol_q   <= o_eol_d;
         s_valid_q <= s_valid_d;
         s_data_q  <= s_data_d;
         s_sof_q   <= s_sof_d;
         s_eol_q   <= s_eol_d;
         col_par_q <= col_par_d;
         row_par_q <= row_par_d;
         ready_q   <= ready_d;
      end
   end

   assign pixel_in_ready  = ready_q;
   assign pixel_out       = o_data_q;
   assign pixel_out_valid = o_valid_q;
   assign pixel_out_sof   = o_sof_q;
   assign pixel_out_eol   = o_eol_q;

endmodule

// File: tb/tb_gray_to_rgb565.sv
// Bench for gray_to_rgb565: one plain (DITHER=0) and one dithered (DITHER=1)
// instance share the input stream; a negedge scoreboard compares every
// output word against an arithmetic model, and directed tasks cover the
// documented corner cases.
module tb_gray_to_rgb565;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  pixel_in;
   logic        in_valid, in_sof, in_eol, out_ready;
   logic        in_ready0, in_ready1;
   logic [15:0] out0, out1;
   logic        ov0, ov1, osof0, osof1, oeol0, oeol1;

   int checks = 0;
   int errors = 0;

   logic [17:0] q0[$];
   logic [17:0] q1[$];
   int          row_m = 0, col_m = 0, ru_m, cu_m;

   always #5 clk = ~clk;

   gray_to_rgb565 #(.DITHER(0)) dut0 (
      .clk(clk), .reset(reset), .pixel_in(pixel_in), .pixel_in_valid(in_valid),
      .pixel_in_sof(in_sof), .pixel_in_eol(in_eol), .pixel_in_ready(in_ready0),
      .pixel_out(out0), .pixel_out_valid(ov0), .pixel_out_sof(osof0),
      .pixel_out_eol(oeol0), .pixel_out_ready(out_ready));

   gray_to_rgb565 #(.DITHER(1)) dut1 (
      .clk(clk), .reset(reset), .pixel_in(pixel_in), .pixel_in_valid(in_valid),
      .pixel_in_sof(in_sof), .pixel_in_eol(in_eol), .pixel_in_ready(in_ready1),
      .pixel_out(out1), .pixel_out_valid(ov1), .pixel_out_sof(osof1),
      .pixel_out_eol(oeol1), .pixel_out_ready(out_ready));

   // Reference conversion: threshold from position, add, divide, clamp.
   function automatic logic [15:0] ref_px(input int g, input int row, input int col,
                                          input bit dith);
      int m, r, gg;
      m = 0;
      if (dith) begin
         if (row == 0) m = (col == 0) ? 0 : 2;
         else          m = (col == 0) ? 3 : 1;
      end
      r  = (g + 2 * m) / 8;
      if (r > 31) r = 31;
      gg = (g + m) / 4;
      if (gg > 63) gg = 63;
      return {r[4:0], gg[5:0], r[4:0]};
   endfunction

   // Scoreboard: inputs change at posedge+1, so negedge sees stable values.
   always @(negedge clk) begin
      if (reset) begin
         q0.delete();
         q1.delete();
         row_m = 0;
         col_m = 0;
      end else begin
         if (ov0 === 1'b1) begin
            checks++;
            if (q0.size() == 0) begin
               errors++;
               $display("FAIL sb_plain_extra got %h expected nothing", out0);
            end else if ({osof0, oeol0, out0} !== q0[0]) begin
               errors++;
               $display("FAIL sb_plain got %h expected %h", {osof0, oeol0, out0}, q0[0]);
            end
            if (out_ready && q0.size() != 0) void'(q0.pop_front());
         end
         if (ov1 === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
               errors++;
               $display("FAIL sb_dither_extra got %h expected nothing", out1);
            end else if ({osof1, oeol1, out1} !== q1[0]) begin
               errors++;
               $display("FAIL sb_dither got %h expected %h", {osof1, oeol1, out1}, q1[0]);
            end
            if (out_ready && q1.size() != 0) void'(q1.pop_front());
         end
         if (in_valid && in_ready0 === 1'b1)
            q0.push_back({in_sof, in_eol, ref_px(int'(pixel_in), 0, 0, 1'b0)});
         if (in_valid && in_ready1 === 1'b1) begin
            ru_m = in_sof ? 0 : row_m;
            cu_m = in_sof ? 0 : col_m;
            q1.push_back({in_sof, in_eol, ref_px(int'(pixel_in), ru_m, cu_m, 1'b1)});
            if (in_eol) begin
               col_m = 0;
               row_m = 1 - ru_m;
            end else begin
               col_m = 1 - cu_m;
               row_m = ru_m;
            end
         end
      end
   end

   task automatic test_reset;
      reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
      pixel_in = 8'h00; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({out0, ov0, osof0, oeol0, in_ready0} !== 20'h0) begin
         errors++;
         $display("FAIL reset_plain got %h expected 0", {out0, ov0, osof0, oeol0, in_ready0});
      end
      checks++;
      if ({out1, ov1, osof1, oeol1, in_ready1} !== 20'h0) begin
         errors++;
         $display("FAIL reset_dither got %h expected 0", {out1, ov1, osof1, oeol1, in_ready1});
      end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset got %b%b expected 11", in_ready0, in_ready1);
      end
   endtask

   task automatic test_plain;
      logic [7:0]  vals [3];
      logic [15:0] expv [3];
      vals = '{8'hFF, 8'h80, 8'h00};
      expv = '{16'hFFFF, 16'h8410, 16'h0000};
      out_ready = 1'b1; in_valid = 1'b1; pixel_in = vals[0];
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (ov0 !== 1'b1 || out0 !== expv[i]) begin
            errors++;
            $display("FAIL plain_%0d got %b/%h expected 1/%h", i, ov0, out0, expv[i]);
         end
         if (i < 2) pixel_in = vals[i + 1];
         else in_valid = 1'b0;
      end
   endtask

   task automatic test_dither_frame;
      logic [15:0] expv [4];
      logic        sofv [4];
      logic        eolv [4];
      expv = '{16'h8430, 16'h8C31, 16'h8C31, 16'h8430};
      sofv = '{1'b1, 1'b0, 1'b0, 1'b0};
      eolv = '{1'b0, 1'b1, 1'b0, 1'b1};
      out_ready = 1'b1; in_valid = 1'b1; pixel_in = 8'h84;
      in_sof = sofv[0]; in_eol = eolv[0];
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (ov1 !== 1'b1 || {osof1, oeol1, out1} !== {sofv[i], eolv[i], expv[i]}) begin
            errors++;
            $display("FAIL frame_%0d got %b/%h expected 1/%h", i, ov1,
                     {osof1, oeol1, out1}, {sofv[i], eolv[i], expv[i]});
         end
         if (i < 3) begin
            in_sof = sofv[i + 1];
            in_eol = eolv[i + 1];
         end else begin
            in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
         end
      end
   endtask

   task automatic test_saturate;
      // sof+eol pixel leaves the position at (1,0) for the next one
      out_ready = 1'b1; in_valid = 1'b1; pixel_in = 8'h10; in_sof = 1'b1; in_eol = 1'b1;
      @(posedge clk); #1;
      pixel_in = 8'hFE; in_sof = 1'b0; in_eol = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (ov1 !== 1'b1 || out1 !== 16'hFFFF) begin
         errors++;
         $display("FAIL saturate_dither got %b/%h expected 1/ffff", ov1, out1);
      end
      checks++;
      if (ov0 !== 1'b1 || out0 !== 16'hFFFF) begin
         errors++;
         $display("FAIL saturate_plain got %b/%h expected 1/ffff", ov0, out0);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_stall;
      logic        fire;
      logic [15:0] held;
      int          acc;
      acc = 0; held = '0;
      in_valid = 1'b1;
      pixel_in = 8'($urandom);
      in_sof = ($urandom_range(0, 7) == 0);
      in_eol = ($urandom_range(0, 5) == 0);
      for (int c = 0; c < 20; c++) begin
         out_ready = !(c >= 5 && c < 10);
         fire = in_ready1;
         if (c >= 5 && c < 10 && fire) acc++;
         if (c == 5) held = out1;
         if (c >= 6 && c < 11) begin
            checks++;
            if (in_ready1 !== 1'b0) begin
               errors++;
               $display("FAIL stall_ready_c%0d got %b expected 0", c, in_ready1);
            end
         end
         if (c >= 6 && c < 10) begin
            checks++;
            if (ov1 !== 1'b1 || out1 !== held) begin
               errors++;
               $display("FAIL stall_hold_c%0d got %b/%h expected 1/%h", c, ov1, out1, held);
            end
         end
         if (c == 11) begin
            checks++;
            if (in_ready1 !== 1'b1) begin
               errors++;
               $display("FAIL stall_recover got %b expected 1", in_ready1);
            end
         end
         if (c >= 10) begin
            checks++;
            if (ov1 !== 1'b1) begin
               errors++;
               $display("FAIL stall_gap_c%0d got %b expected 1", c, ov1);
            end
         end
         @(posedge clk); #1;
         if (fire) begin
            pixel_in = 8'($urandom);
            in_sof = ($urandom_range(0, 7) == 0);
            in_eol = ($urandom_range(0, 5) == 0);
         end
      end
      checks++;
      if (acc != 1) begin
         errors++;
         $display("FAIL stall_accepts got %0d expected 1", acc);
      end
      in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; out_ready = 1'b1;
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b0; in_valid = 1'b1; pixel_in = 8'h84; in_sof = 1'b0; in_eol = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ov1 !== 1'b1 || in_ready1 !== 1'b0) begin
         errors++;
         $display("FAIL mid_full got %b%b expected 10", ov1, in_ready1);
      end
      reset = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({out1, ov1, osof1, oeol1, in_ready1, out0, ov0, in_ready0} !== 38'h0) begin
         errors++;
         $display("FAIL mid_reset got %h/%b/%b expected 0/0/0", out1, ov1, in_ready1);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b1; pixel_in = 8'h84;
      @(posedge clk); #1;
      checks++;
      if (ov1 !== 1'b1 || out1 !== 16'h8430) begin
         errors++;
         $display("FAIL mid_first got %b/%h expected 1/8430", ov1, out1);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_sof_midline;
      logic [15:0] expv [4];
      logic        sofv [4];
      expv = '{16'h8430, 16'h8C31, 16'h8430, 16'h8C31};
      sofv = '{1'b1, 1'b0, 1'b1, 1'b0};
      out_ready = 1'b1; in_valid = 1'b1; pixel_in = 8'h84; in_eol = 1'b0; in_sof = sofv[0];
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (ov1 !== 1'b1 || out1 !== expv[i] || osof1 !== sofv[i]) begin
            errors++;
            $display("FAIL sof_mid_%0d got %b/%b/%h expected 1/%b/%h", i, ov1, osof1, out1,
                     sofv[i], expv[i]);
         end
         if (i < 3) in_sof = sofv[i + 1];
         else begin
            in_valid = 1'b0; in_sof = 1'b0;
         end
      end
   endtask

   task automatic test_random;
      int waited;
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         pixel_in  = 8'($urandom);
         in_sof    = ($urandom_range(0, 15) == 0);
         in_eol    = ($urandom_range(0, 6) == 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; out_ready = 1'b1;
      waited = 0;
      while ((q0.size() != 0 || q1.size() != 0) && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d/%0d pending expected 0/0", q0.size(), q1.size());
      end
   endtask

   initial begin
      reset = 1'b1;
      test_reset();
      test_plain();
      test_dither_frame();
      test_saturate();
      test_stall();
      test_reset_mid();
      test_sof_midline();
      test_random();
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
